// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared RAM handshake and arbiter state types
package mem_arbiter_pkg;
  typedef logic [31:0] word_t;
  typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;
  typedef enum logic [1:0] {IDLE, DSERV, ISERV} arb_state_t;
endpackage

// File: rtl/mem_arbiter_wait_timer.sv
// mem_arbiter_wait_timer: saturating wait counter with sticky compare-to-TIMEOUT flag
// Ports: clk, rst (sync, active-high); clr zeroes the count; en counts one wait cycle;
// flag goes high when the count reaches TIMEOUT and stays high until rst.
module mem_arbiter_wait_timer #(
  parameter int TIMEOUT = 255,
  parameter int TW = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic flag
);
  logic [TW-1:0] cnt, cnt_inc;
  assign cnt_inc = (cnt == '1) ? cnt : cnt + TW'(1);
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      flag <= 1'b0;
    end else begin
      cnt <= clr ? '0 : en ? cnt_inc : cnt;
      flag <= flag | (en && cnt_inc == TW'(TIMEOUT));
    end
  end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates fetch and data ports onto one RAM port, producing ihit/dhit
// Ports: CLK/RST (sync, active-high); iREN/iaddr fetch request; dREN/dWEN/daddr/dstore
// data request; ihit/iload, dhit/dload responses; ramREN/ramWEN/ramaddr/ramstore/
// ramload/ramstate RAM side; timeout, ram_err sticky status.
// Optional MEM_ARBITER_STATS_EN adds icount, dcount, stallcount counters.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int TW = 8
) (
  input  logic      CLK,
  input  logic      RST,
  input  logic      iREN,
  input  word_t     iaddr,
  input  logic      dREN,
  input  logic      dWEN,
  input  word_t     daddr,
  input  word_t     dstore,
  output logic      ihit,
  output logic      dhit,
  output word_t     iload,
  output word_t     dload,
  output logic      ramREN,
  output logic      ramWEN,
  output word_t     ramaddr,
  output word_t     ramstore,
  input  word_t     ramload,
  input  ramstate_t ramstate,
  output logic      timeout,
  output logic      ram_err
`ifdef MEM_ARBITER_STATS_EN
  ,
  output logic [31:0] icount,
  output logic [31:0] dcount,
  output logic [31:0] stallcount
`endif
);
  arb_state_t state, next;
  logic dreq, acc, stall;
  assign dreq = dREN | dWEN;
  assign acc = ramstate == ACCESS;
  assign stall = state != IDLE && !acc;
  always_ff @(posedge CLK) begin
    state <= RST ? IDLE : next;
    ram_err <= RST ? 1'b0 : ram_err | (state != IDLE && ramstate == ERROR);
  end
  always_comb begin
    next = state;
    ihit = 1'b0;
    dhit = 1'b0;
    iload = '0;
    dload = '0;
    ramREN = 1'b0;
    ramWEN = 1'b0;
    ramaddr = '0;
    ramstore = '0;
    case (state)
      IDLE: next = dreq ? DSERV : iREN ? ISERV : IDLE;
      DSERV: begin
        ramaddr = daddr;
        ramstore = dstore;
        ramWEN = dWEN;
        ramREN = dREN & ~dWEN;
        dhit = dreq && acc;
        dload = dhit ? ramload : '0;
        next = (!dreq || ramstate == ERROR) ? IDLE : acc ? (iREN ? ISERV : IDLE) : DSERV;
      end
      ISERV: begin
        ramaddr = iaddr;
        ramREN = 1'b1;
        ihit = iREN && acc;
        iload = ihit ? ramload : '0;
        next = (!iREN || ramstate == ERROR) ? IDLE : (acc && dreq) ? DSERV : ISERV;
      end
      default: next = IDLE;
    endcase
  end
  // Counting is cleared in IDLE and on every ACCESS, so each service entry starts from zero.
  mem_arbiter_wait_timer #(.TIMEOUT(TIMEOUT), .TW(TW)) u_timer (
    .clk(CLK),
    .rst(RST),
    .clr(state == IDLE || acc),
    .en(stall),
    .flag(timeout)
  );
`ifdef MEM_ARBITER_STATS_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      icount <= '0;
      dcount <= '0;
      stallcount <= '0;
    end else begin
      icount <= icount + {31'd0, ihit};
      dcount <= dcount + {31'd0, dhit};
      stallcount <= stallcount + {31'd0, stall};
    end
  end
`endif
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed stimulus with a hit scoreboard checked by a separate monitor
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;
  logic CLK = 0, RST = 1, iREN = 0, dREN = 0, dWEN = 0;
  logic [31:0] iaddr = 0, daddr = 0, dstore = 0, ramload = 0;
  ramstate_t ramstate = FREE;
  logic ihit, dhit, ramREN, ramWEN, timeout, ram_err;
  logic [31:0] iload, dload, ramaddr, ramstore;
`ifdef MEM_ARBITER_STATS_EN
  logic [31:0] icount, dcount, stallcount;
`endif
  int vectors = 0, miscompares = 0;
  typedef struct {logic is_i; logic [31:0] data;} exp_t;
  exp_t q[$];

  mem_arbiter #(.TIMEOUT(4), .TW(8)) dut (
    .CLK(CLK), .RST(RST), .iREN(iREN), .iaddr(iaddr), .dREN(dREN), .dWEN(dWEN),
    .daddr(daddr), .dstore(dstore), .ihit(ihit), .dhit(dhit), .iload(iload),
    .dload(dload), .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
    .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate),
    .timeout(timeout), .ram_err(ram_err)
`ifdef MEM_ARBITER_STATS_EN
    , .icount(icount), .dcount(dcount), .stallcount(stallcount)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic sample();
    @(negedge CLK);
  endtask

  task automatic expect_hit(input logic is_i, input logic [31:0] d);
    exp_t e;
    e.is_i = is_i;
    e.data = d;
    q.push_back(e);
  endtask

  always @(negedge CLK) begin
    exp_t e;
    if (!RST) begin
      chk("one_hit", {31'd0, ihit & dhit}, 0);
      chk("iload_zero", ihit ? 32'd0 : iload, 0);
      chk("dload_zero", dhit ? 32'd0 : dload, 0);
      if (ihit | dhit) begin
        if (q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_hit: got ihit=%b dhit=%b expected no hit", ihit, dhit);
        end else begin
          e = q.pop_front();
          chk("hit_kind", {31'd0, ihit}, {31'd0, e.is_i});
          chk("hit_load", ihit ? iload : dload, e.data);
        end
      end
    end
  end

  initial begin
    RST = 1;
    repeat (2) step();
    RST = 0;
    sample();
    chk("rst_ren", ramREN, 0);
    chk("rst_wen", ramWEN, 0);
    chk("rst_ihit", ihit, 0);
    chk("rst_dhit", dhit, 0);
    chk("rst_iload", iload, 0);
    chk("rst_dload", dload, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_ram_err", ram_err, 0);
`ifdef MEM_ARBITER_STATS_EN
    chk("rst_icount", icount, 0);
    chk("rst_stallcount", stallcount, 0);
`endif
    // fetch with two BUSY cycles
    step(); iREN = 1; iaddr = 32'h40; ramstate = BUSY; sample();
    chk("idle_no_ren", ramREN, 0);
    step(); sample();
    chk("iserv_ren", ramREN, 1);
    chk("iserv_addr", ramaddr, 32'h40);
    step(); sample();
    step(); ramstate = ACCESS; ramload = 32'h8C220004; expect_hit(1, 32'h8C220004); sample();
    chk("ifetch_dhit", dhit, 0);
    step(); iREN = 0; ramstate = FREE; sample();
    step(); sample();
    chk("idle_after_iwd", ramREN, 0);
    // simultaneous fetch and write: data first, then fetch
    step(); iREN = 1; iaddr = 32'h200; dWEN = 1; daddr = 32'h100; dstore = 32'hDEADBEEF;
    ramstate = ACCESS; ramload = 32'h11111111; sample();
    step(); expect_hit(0, 32'h11111111); sample();
    chk("wr_wen", ramWEN, 1);
    chk("wr_ren", ramREN, 0);
    chk("wr_addr", ramaddr, 32'h100);
    chk("wr_store", ramstore, 32'hDEADBEEF);
    step(); dWEN = 0; ramload = 32'h22222222; expect_hit(1, 32'h22222222); sample();
    chk("if2_addr", ramaddr, 32'h200);
    chk("if2_ren", ramREN, 1);
    chk("if2_wen", ramWEN, 0);
    step(); iREN = 0; ramstate = FREE; sample();
    step(); sample();
    // dREN and dWEN together, then withdrawal with ACCESS present
    step(); dREN = 1; dWEN = 1; daddr = 32'h300; dstore = 32'h5; ramstate = BUSY; sample();
    step(); sample();
    chk("both_wen", ramWEN, 1);
    chk("both_ren", ramREN, 0);
    chk("both_addr", ramaddr, 32'h300);
    step(); dREN = 0; dWEN = 0; ramstate = ACCESS; sample();
    chk("wd_wen", ramWEN, 0);
    chk("wd_ren", ramREN, 0);
    step(); ramstate = FREE; sample();
    chk("after_wd_ren", ramREN, 0);
    chk("after_wd_wen", ramWEN, 0);
    // data read
    step(); dREN = 1; daddr = 32'h44; ramstate = BUSY; sample();
    step(); sample();
    chk("rd_ren", ramREN, 1);
    chk("rd_wen", ramWEN, 0);
    step(); ramstate = ACCESS; ramload = 32'hCAFEF00D; expect_hit(0, 32'hCAFEF00D); sample();
    step(); dREN = 0; ramstate = FREE; sample();
    chk("rd_done_ren", ramREN, 0);
`ifdef MEM_ARBITER_STATS_EN
    chk("icount", icount, 2);
    chk("dcount", dcount, 2);
`endif
    // RAM error during fetch
    step(); iREN = 1; iaddr = 32'h80; sample();
    step(); ramstate = ERROR; sample();
    chk("err_pre", ram_err, 0);
    step(); iREN = 0; ramstate = FREE; sample();
    chk("err_set", ram_err, 1);
    chk("err_idle_ren", ramREN, 0);
    step(); sample();
    chk("err_sticky", ram_err, 1);
    step(); RST = 1; sample();
    step(); RST = 0; sample();
    chk("err_clr", ram_err, 0);
    // timeout with TIMEOUT=4
    step(); iREN = 1; iaddr = 32'hC0; ramstate = BUSY; sample();
    for (int k = 1; k <= 4; k++) begin
      step(); sample();
      chk($sformatf("to_wait%0d", k), timeout, 0);
    end
    step(); sample();
    chk("to_set", timeout, 1);
`ifdef MEM_ARBITER_STATS_EN
    chk("stallcount", stallcount, 4);
`endif
    step(); iREN = 0; ramstate = FREE; sample();
    step(); sample();
    chk("to_sticky", timeout, 1);
    repeat (2) step();
    chk("queue_drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Responder side of the pipeline's stall handshake; generates the `ihit`/`dhit` pulses the hazard unit consumes to enable or stall pipeline registers.
- Arbitrates the fetch port (IF) and data port (MEM) onto a single RAM port.
- Data requests win ties; after a data service, fetch gets the next grant, so fetch is never starved.
- Sits between the datapath and RAM, replacing direct RAM wiring.

Parameters:
- TIMEOUT, 255: wait cycles in a service state before `timeout` is flagged.
- TW, 8: width of the wait counter; TIMEOUT must be < 2^TW.

Ports:
- CLK  in  1  clock, rising edge
- RST  in  1  reset, synchronous, active-high
- iREN  in  1  instruction read request
- iaddr  in  32  instruction word address
- dREN  in  1  data read request
- dWEN  in  1  data write request
- daddr  in  32  data address
- dstore  in  32  data write value
- ihit  out  1  instruction served this cycle
- dhit  out  1  data served this cycle
- iload  out  32  instruction word
- dload  out  32  read data
- ramREN  out  1  RAM read strobe
- ramWEN  out  1  RAM write strobe
- ramaddr  out  32  RAM address
- ramstore  out  32  RAM write data
- ramload  in  32  RAM read data
- ramstate  in  ramstate_t  FREE/BUSY/ACCESS/ERROR
- timeout  out  1  sticky: a wait exceeded TIMEOUT
- ram_err  out  1  sticky: RAM returned ERROR

Behaviour:
- State machine states: IDLE, DSERV, ISERV. Outputs are combinational from state and inputs; state and counters are registered.
- Reset: state=IDLE, wait counter=0, timeout=0, ram_err=0. In the cycle after RST, all ram strobes and hits are 0 and loads are 0.
- Reset during DSERV/ISERV: the request is dropped with no hit; the RAM sees its strobe fall next cycle.
- IDLE: drives no RAM strobes and no hits.
  - If dREN|dWEN, go to DSERV.
  - Else if iREN, go to ISERV.
  - Else stay in IDLE.
  - This gives a minimum 2-cycle latency from request to hit.
- DSERV:
  - ramaddr=daddr, ramstore=dstore.
  - If dWEN, ramWEN=1 and ramREN=0; dWEN wins if both dREN and dWEN are set. Else ramREN=dREN.
  - When ramstate==ACCESS: dhit=1 for that cycle, dload=ramload. Next state is ISERV if iREN, else IDLE.
- ISERV:
  - ramaddr=iaddr, ramREN=1.
  - When ramstate==ACCESS: ihit=1, iload=ramload. Next state is DSERV if dREN|dWEN, else ISERV if iREN, else IDLE.
- ihit and dhit are never high in the same cycle. Each is a 1-cycle pulse per access.
- Withdrawal: if the owning request drops while in a service state (flush), return to IDLE next cycle with no hit. This applies to dREN=dWEN=0 in DSERV and iREN=0 in ISERV.
- ramstate==ERROR in a service state:
  - Set ram_err.
  - No hit.
  - Return to IDLE. The requester retries.
- Wait counter:
  - Cleared on entry to a service state.
  - Increments each cycle in a service state without ACCESS; saturates at 2^TW-1.
  - When it reaches TIMEOUT, timeout is set. timeout and ram_err clear only on RST.
- loads are 0 whenever the corresponding hit is 0.

Optional Feature:
- Macro MEM_ARBITER_STATS_EN.
- Defined:
  - Adds 32-bit output counters `icount`, `dcount` (hits served) and `stallcount` (cycles in a service state without ACCESS).
  - All three reset to 0 and wrap at 2^32.
- Undefined: no counter ports or logic exist.

Decomposition:
- arb_state_t {IDLE, DSERV, ISERV} goes into the shared pipeline types package alongside the mux-selection enums.
- ramstate_t and word_t come from cpu_types_pkg.
- One natural sub-module, `wait_timer`: clear/enable/saturating counter with a compare-to-TIMEOUT sticky flag.

Test Plan:
- iREN=1, iaddr=0x40, ramstate=BUSY for 2 cycles then ACCESS with ramload=0x8C220004 -> ihit pulses 1 cycle in the ACCESS cycle, iload=0x8C220004, dhit=0 throughout.
- iREN=1 and dWEN=1 both from IDLE, daddr=0x100, dstore=0xDEADBEEF, ramstate=ACCESS -> DSERV first with ramWEN=1, ramaddr=0x100, dhit=1; next cycle ISERV with ramaddr=iaddr and ihit on ACCESS.
- dREN and dWEN both 1 -> ramWEN=1, ramREN=0.
- In DSERV, drop dREN/dWEN before ACCESS -> IDLE next cycle, no dhit, ram strobes 0.
- ramstate=ERROR during ISERV -> ram_err=1 sticky, no ihit, IDLE; then RST=1 for 1 cycle -> ram_err=0.
- TIMEOUT=4, ramstate held BUSY -> timeout=1 after the 4th wait cycle; with STATS_EN, stallcount increments every BUSY cycle.
